// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_pkg : phase encoding, lamp one-hot codes and default phase timings  |
// | for traffic_phase_ctrl. The WALK phase exists only when PED_WALK_EN is set. |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
package traffic_pkg;

`ifdef PED_WALK_EN
  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5,
    WALK = 3'd6
  } phase_e;
`else
  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5
  } phase_e;
`endif

  // Lamp vectors are {red, yellow, green}
  localparam logic [2:0] c_LIGHT_RED    = 3'b100;
  localparam logic [2:0] c_LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] c_LIGHT_GREEN  = 3'b001;

  localparam int c_DEF_GREEN_TIME  = 29;
  localparam int c_DEF_YELLOW_TIME = 4;
  localparam int c_DEF_RED_TIME    = 2;
  localparam int c_DEF_WALK_TIME   = 10;
  localparam int c_DEF_CNT_W       = 8;

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phase_timer : tick-enabled phase counter with synchronous clear and a      |
// | terminal-count strobe raised on the tick that completes the phase.         |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module phase_timer
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // last_i holds duration-1, so the phase spans exactly `duration` ticks
  assign done_o = inc_i && (cnt_q == last_i);

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_phase_ctrl : two-road signal sequencer with all-red clearance and  |
// | an optional pedestrian WALK phase enabled by the PED_WALK_EN macro.        |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_TIME  = c_DEF_GREEN_TIME,
  parameter int YELLOW_TIME = c_DEF_YELLOW_TIME,
  parameter int RED_TIME    = c_DEF_RED_TIME,
  parameter int WALK_TIME   = c_DEF_WALK_TIME,
  parameter int CNT_W       = c_DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       en,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] c_GREEN_LAST  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] c_YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] c_RED_LAST    = CNT_W'(RED_TIME - 1);
`ifdef PED_WALK_EN
  localparam logic [CNT_W-1:0] c_WALK_LAST   = CNT_W'(WALK_TIME - 1);
`endif

  phase_e           state_q;
  phase_e           state_d;
  logic [CNT_W-1:0] w_last;
  logic             w_adv;
  logic             w_done;

  assign w_adv = tick & en;

  always_comb begin
    w_last = c_RED_LAST;
    case (state_q)
      NS_G, EW_G: w_last = c_GREEN_LAST;
      NS_Y, EW_Y: w_last = c_YELLOW_LAST;
      AR1, AR2:   w_last = c_RED_LAST;
`ifdef PED_WALK_EN
      WALK:       w_last = c_WALK_LAST;
`endif
      default:    w_last = c_RED_LAST;
    endcase
  end

  // Every phase exits on its terminal tick, so done doubles as the timer clear
  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (w_done),
    .inc_i  (w_adv),
    .last_i (w_last),
    .done_o (w_done)
  );

`ifdef PED_WALK_EN
  logic ped_pend_q;
  logic ped_pend_d;
  logic ped_ack_q;
  logic ped_ack_d;
  logic w_go_walk;
  logic w_walk_entry;

  // A press landing on the AR2 exit cycle joins the walk it triggers
  assign w_go_walk = ped_pend_q | ped_req;
`endif

  always_comb begin
    state_d = state_q;
    if (w_done) begin
      case (state_q)
        NS_G:    state_d = NS_Y;
        NS_Y:    state_d = AR1;
        AR1:     state_d = EW_G;
        EW_G:    state_d = EW_Y;
        EW_Y:    state_d = AR2;
`ifdef PED_WALK_EN
        AR2:     state_d = w_go_walk ? WALK : NS_G;
        WALK:    state_d = NS_G;
`else
        AR2:     state_d = NS_G;
`endif
        default: state_d = NS_G;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NS_G;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PED_WALK_EN
  always_comb begin
    w_walk_entry = (state_q == AR2) && (state_d == WALK);
    ped_ack_d    = w_walk_entry;
    ped_pend_d   = ped_pend_q;
    if (w_walk_entry) begin
      ped_pend_d = 1'b0;
    end else if (ped_req && (state_q != WALK)) begin
      ped_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend_q <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      ped_ack_q  <= ped_ack_d;
    end
  end

  assign walk    = (state_q == WALK);
  assign ped_ack = ped_ack_q;
`else
  assign walk    = 1'b0;
  assign ped_ack = 1'b0;
`endif

  // Lamps decode from the state register only; red is the safe default
  always_comb begin
    ns_light = c_LIGHT_RED;
    ew_light = c_LIGHT_RED;
    case (state_q)
      NS_G:    ns_light = c_LIGHT_GREEN;
      NS_Y:    ns_light = c_LIGHT_YELLOW;
      EW_G:    ew_light = c_LIGHT_GREEN;
      EW_Y:    ew_light = c_LIGHT_YELLOW;
      default: begin
        ns_light = c_LIGHT_RED;
        ew_light = c_LIGHT_RED;
      end
    endcase
  end

  assign phase = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// Directed self-checking bench for traffic_phase_ctrl with GREEN=3, YELLOW=2,
// RED=1, WALK=2; pedestrian scenarios follow the PED_WALK_EN build option.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;
  localparam logic [2:0] PH_WALK = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       en;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_phase_ctrl #(
    .GREEN_TIME  (3),
    .YELLOW_TIME (2),
    .RED_TIME    (1),
    .WALK_TIME   (2),
    .CNT_W       (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .en       (en),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .ped_ack  (ped_ack),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  // Expected phase k clocks after entering NS_G with no pedestrian activity
  function automatic logic [2:0] cyc_phase(input int k);
    int m;
    m = k % 12;
    if (m < 3)       return 3'd0;
    else if (m < 5)  return 3'd1;
    else if (m < 6)  return 3'd2;
    else if (m < 9)  return 3'd3;
    else if (m < 11) return 3'd4;
    else             return 3'd5;
  endfunction

  function automatic logic [5:0] lights_of(input logic [2:0] ph);
    case (ph)
      3'd0:    return {L_G, L_R};
      3'd1:    return {L_Y, L_R};
      3'd3:    return {L_R, L_G};
      3'd4:    return {L_R, L_Y};
      default: return {L_R, L_R};
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b1; en = 1'b1; ped_req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    n_checks++;
    if ({ns_light, ew_light} !== {L_G, L_R}) begin n_fail++; $display("FAIL reset_lights: got %b expected %b", {ns_light, ew_light}, {L_G, L_R}); end
    n_checks++;
    if (walk !== 1'b0) begin n_fail++; $display("FAIL reset_walk: got %b expected 0", walk); end
    n_checks++;
    if (ped_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ped_ack); end
    rst_n = 1'b1;
  endtask

  // Two full cycles straight out of reset
  task automatic test_power_up();
    logic [2:0] exp;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp = cyc_phase(k);
      n_checks++;
      if (phase !== exp) begin n_fail++; $display("FAIL pu_phase k=%0d: got %0d expected %0d", k, phase, exp); end
      n_checks++;
      if ({ns_light, ew_light} !== lights_of(exp)) begin n_fail++; $display("FAIL pu_lights k=%0d: got %b expected %b", k, {ns_light, ew_light}, lights_of(exp)); end
      n_checks++;
      if (ns_light !== L_R && ew_light !== L_R) begin n_fail++; $display("FAIL pu_conflict k=%0d: ns=%b ew=%b expected one red", k, ns_light, ew_light); end
      n_checks++;
      if (walk !== 1'b0 || ped_ack !== 1'b0) begin n_fail++; $display("FAIL pu_walk k=%0d: walk=%b ack=%b expected 0 0", k, walk, ped_ack); end
    end
  endtask

`ifdef PED_WALK_EN
  // Press at k1, second press during WALK must be ignored
  task automatic test_ped_walk();
    logic [2:0] exp;
    for (int k = 1; k <= 26; k++) begin
      ped_req = (k == 1) || (k == 13);
      @(negedge clk);
      ped_req = 1'b0;
      if (k <= 11)      exp = cyc_phase(k);
      else if (k <= 13) exp = PH_WALK;
      else              exp = cyc_phase(k - 14);
      n_checks++;
      if (phase !== exp) begin n_fail++; $display("FAIL ped_phase k=%0d: got %0d expected %0d", k, phase, exp); end
      n_checks++;
      if ({ns_light, ew_light} !== lights_of(exp)) begin n_fail++; $display("FAIL ped_lights k=%0d: got %b expected %b", k, {ns_light, ew_light}, lights_of(exp)); end
      n_checks++;
      if (walk !== (exp == PH_WALK)) begin n_fail++; $display("FAIL ped_walk k=%0d: got %b expected %b", k, walk, (exp == PH_WALK)); end
      n_checks++;
      if (ped_ack !== (k == 12)) begin n_fail++; $display("FAIL ped_ack k=%0d: got %b expected %b", k, ped_ack, (k == 12)); end
    end
  endtask

  // Pending press plus a second press on the AR2 exit cycle: one walk only
  task automatic test_same_cycle();
    logic [2:0] exp;
    for (int k = 1; k <= 26; k++) begin
      ped_req = (k == 2) || (k == 12);
      @(negedge clk);
      ped_req = 1'b0;
      if (k <= 11)      exp = cyc_phase(k);
      else if (k <= 13) exp = PH_WALK;
      else              exp = cyc_phase(k - 14);
      n_checks++;
      if (phase !== exp) begin n_fail++; $display("FAIL same_phase k=%0d: got %0d expected %0d", k, phase, exp); end
      n_checks++;
      if (ped_ack !== (k == 12)) begin n_fail++; $display("FAIL same_ack k=%0d: got %b expected %b", k, ped_ack, (k == 12)); end
    end
  endtask
`else
  task automatic test_no_ped();
    logic [2:0] exp;
    for (int k = 1; k <= 12; k++) begin
      ped_req = (k == 1) || (k == 11);
      @(negedge clk);
      ped_req = 1'b0;
      exp = cyc_phase(k);
      n_checks++;
      if (phase !== exp) begin n_fail++; $display("FAIL noped_phase k=%0d: got %0d expected %0d", k, phase, exp); end
      n_checks++;
      if (walk !== 1'b0 || ped_ack !== 1'b0) begin n_fail++; $display("FAIL noped_walk k=%0d: walk=%b ack=%b expected 0 0", k, walk, ped_ack); end
    end
  endtask
`endif

  task automatic test_hold();
    logic [2:0] exp;
    int         n_res;
    repeat (7) @(negedge clk);
    n_checks++;
    if (phase !== 3'd3) begin n_fail++; $display("FAIL hold_pre: got %0d expected 3", phase); end
    en = 1'b0;
    for (int h = 1; h <= 5; h++) begin
      ped_req = (h == 2);
      @(negedge clk);
      ped_req = 1'b0;
      n_checks++;
      if (phase !== 3'd3 || {ns_light, ew_light} !== {L_R, L_G} || walk !== 1'b0) begin
        n_fail++; $display("FAIL hold_frozen h=%0d: phase=%0d lights=%b walk=%b expected 3 %b 0", h, phase, {ns_light, ew_light}, walk, {L_R, L_G});
      end
    end
    en = 1'b1;
`ifdef PED_WALK_EN
    n_res = 7;
`else
    n_res = 5;
`endif
    for (int r = 1; r <= n_res; r++) begin
      @(negedge clk);
      if (r == 1)             exp = 3'd3;
      else if (r <= 3)        exp = 3'd4;
      else if (r == 4)        exp = 3'd5;
      else if (r == n_res)    exp = 3'd0;
      else                    exp = PH_WALK;
      n_checks++;
      if (phase !== exp) begin n_fail++; $display("FAIL hold_resume r=%0d: got %0d expected %0d", r, phase, exp); end
    end
  endtask

  task automatic test_slow_tick();
    logic [2:0] exp;
    for (int c = 1; c <= 12; c++) begin
      tick = ((c % 4) == 0);
      @(negedge clk);
      exp = (c < 12) ? 3'd0 : 3'd1;
      n_checks++;
      if (phase !== exp) begin n_fail++; $display("FAIL slow_phase c=%0d: got %0d expected %0d", c, phase, exp); end
    end
    tick = 1'b1;
  endtask

  // Starts in NS_Y with timer 0; reset lands mid EW_Y with a press pending
  task automatic test_reset_mid();
    logic [2:0] exp;
    for (int k = 1; k <= 7; k++) begin
      ped_req = (k == 7);
      @(negedge clk);
      ped_req = 1'b0;
    end
    n_checks++;
    if (phase !== 3'd4) begin n_fail++; $display("FAIL rmid_pre: got %0d expected 4", phase); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (phase !== 3'd0) begin n_fail++; $display("FAIL rmid_phase: got %0d expected 0", phase); end
    n_checks++;
    if ({ns_light, ew_light} !== {L_G, L_R} || walk !== 1'b0 || ped_ack !== 1'b0) begin
      n_fail++; $display("FAIL rmid_outs: lights=%b walk=%b ack=%b expected %b 0 0", {ns_light, ew_light}, walk, ped_ack, {L_G, L_R});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      exp = cyc_phase(k);
      n_checks++;
      if (phase !== exp || walk !== 1'b0) begin n_fail++; $display("FAIL rmid_after k=%0d: phase=%0d walk=%b expected %0d 0", k, phase, walk, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
`ifdef PED_WALK_EN
    test_ped_walk();
    test_same_cycle();
`else
    test_no_ped();
`endif
    test_hold();
    test_slow_tick();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameters SHALL be declared as name, default, meaning, one per line below.
- GREEN_TIME, 29, green duration in ticks (>=1)
- YELLOW_TIME, 4, yellow duration in ticks (>=1)
- RED_TIME, 2, all-red clearance duration in ticks (>=1)
- WALK_TIME, 10, pedestrian walk duration in ticks (>=1)
- CNT_W, 8, phase timer width; every *_TIME SHALL fit in CNT_W bits
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- tick  in  1  time-base strobe; timer advances only on cycles with tick=1
- en  in  1  run enable; 0 = hold
- ped_req  in  1  pedestrian button, level or pulse, sampled every clk
- ns_light  out  3  {red,yellow,green}, one-hot
- ew_light  out  3  {red,yellow,green}, one-hot
- walk  out  1  walk lamp
- ped_ack  out  1  one-cycle pulse on WALK entry
- phase  out  3  current state encoding (package enum)

Function
REQ-003 FSM states SHALL be NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, WALK.
REQ-004 Transition order SHALL be NS_G->NS_Y->AR1->EW_G->EW_Y->AR2->(WALK if ped_pend, else NS_G); WALK->NS_G.
REQ-005 Phase timer SHALL clear to 0 on every state change and SHALL increment on each cycle with tick=1 and en=1.
REQ-006 A state with duration T SHALL exit at the clk edge of the cycle where tick=1, en=1 and timer==T-1, so each state lasts exactly T ticks.
REQ-007 Lights SHALL be: NS_G ns=green/ew=red; NS_Y ns=yellow/ew=red; EW_G ew=green/ns=red; EW_Y ew=yellow/ns=red; AR1, AR2, WALK both red.
REQ-008 Both directions SHALL never be non-red in the same cycle.
REQ-009 walk SHALL be 1 exactly while in WALK.
REQ-010 ped_req=1 in any state other than WALK SHALL set sticky ped_pend; ped_req during WALK SHALL be ignored.
REQ-011 On WALK entry, ped_pend SHALL clear and ped_ack SHALL pulse high for one clk.
REQ-012 ped_req on the same cycle as the AR2->WALK transition SHALL be consumed by that walk, with no second walk.
REQ-013 en=0 SHALL freeze state, timer and outputs; ped_req SHALL still latch; en=1 SHALL resume with the remaining duration intact.
REQ-014 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs.

Reset
REQ-015 rst_n=0 SHALL force, at any time including mid-phase: state NS_G, timer 0, ped_pend 0, ns_light=green, ew_light=red, walk 0, ped_ack 0.
REQ-016 The first tick after reset release SHALL count as tick 1 of NS_G.

Configuration
REQ-017 Macro PED_WALK_EN SHALL gate the pedestrian feature.
REQ-018 With PED_WALK_EN defined, REQ-009..012 apply.
REQ-019 Without PED_WALK_EN, WALK and ped_pend SHALL not exist, AR2 SHALL always go to NS_G, ped_req SHALL be ignored, and walk and ped_ack SHALL be tied 0.

Structure
REQ-020 Package traffic_pkg SHALL hold the phase enum, the light one-hot constants and the default time values.
REQ-021 Sub-module phase_timer SHALL implement the CNT_W counter with clear, tick-enable and terminal-count compare; the FSM SHALL live in traffic_phase_ctrl.

Verification
Bench parameters: GREEN=3, YELLOW=2, RED=1, WALK=2; tick every clk unless stated.
REQ-022 Release reset -> ns=green/ew=red; NS_Y after 3 clks; AR1 after 5; EW_G after 6.
REQ-023 No ped_req -> full cycle of 12 ticks returns to NS_G; never both non-red.
REQ-024 1-clk ped_req during NS_G -> after AR2: WALK, walk=1 for 2 clks, one ped_ack pulse, then NS_G; next cycle has no WALK.
REQ-025 en=0 for 5 clks at EW_G timer=1 -> outputs constant; after en=1, EW_G lasts 2 more ticks.
REQ-026 tick every 4th clk -> NS_G lasts 12 clks; no state change on tick=0 cycles.
REQ-027 rst_n low mid EW_Y with ped_pend=1 -> immediate NS_G, pending cleared, no WALK in following cycle.
